// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM responder for M-stage load/store requests with fixed latency and RV32I lane handling.
// Optional build macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [2:0]  Req_Funct3,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err,
  output logic        Busy
);

  // state  | meaning
  // IDLE   | ready to accept one request
  // WAIT   | fixed latency countdown
  // ACCESS | error check, RAM write commit or read/extend
  // RESP   | response held until Resp_Ready
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic          range_err;
  logic          funct_err;
  logic          misalign_err;
  logic          access_err;
  logic [31:0]   ram_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [3:0]    store_be;
  logic [31:0]   store_data;
  logic          mem_we;

  assign Req_Ready  = (state == IDLE);
  assign Resp_Valid = (state == RESP);
  assign Busy       = (state != IDLE);
  assign Resp_RData = resp_rdata_q;
  assign Resp_Err   = resp_err_q;

  assign word_idx  = {2'b00, addr_q[31:2]};
  assign ram_idx   = word_idx[AW-1:0];
  assign range_err = (word_idx >= 32'(DEPTH_WORDS));
  assign funct_err = write_q ? !(funct3_q inside {3'b000, 3'b001, 3'b010})
                             :  (funct3_q inside {3'b011, 3'b110, 3'b111});

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign_err = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                        ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif

  assign access_err = range_err | funct_err | misalign_err;
  assign ram_word   = mem[ram_idx];
  assign half_sel   = addr_q[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    byte_sel = ram_word[7:0];
    case (addr_q[1:0])
      2'b01:   byte_sel = ram_word[15:8];
      2'b10:   byte_sel = ram_word[23:16];
      2'b11:   byte_sel = ram_word[31:24];
      default: byte_sel = ram_word[7:0];
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      3'b010:  load_data = ram_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_be   = 4'b0000;
    store_data = 32'd0;
    case (funct3_q)
      3'b000: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
      default: begin
        store_be   = 4'b0000;
        store_data = 32'd0;
      end
    endcase
  end

  assign mem_we = (state == ACCESS) && write_q && !access_err;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) mem[ram_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            write_q  <= Req_Write;
            funct3_q <= Req_Funct3;
            addr_q   <= Req_Addr;
            wdata_q  <= Req_WData;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ACCESS: begin
          resp_err_q   <= access_err;
          resp_rdata_q <= (write_q || access_err) ? 32'd0 : load_data;
          state        <= RESP;
        end
        RESP: begin
          if (Resp_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the M-stage load/store request interface: accepts one request per transaction, waits a fixed number of cycles, then returns load data or a store acknowledge.
- Holds the data RAM and does RV32I byte/halfword lane selection and load sign/zero extension, so the write-back path receives a final 32-bit value.
- Sits between the M-stage request/stall logic and the write-back Read_Data register.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in RAM; address word index = Req_Addr[31:2].
WAIT_CYCLES, 2, extra wait cycles between accept and response (legal 0..15).

Ports:
Clk  in  1  clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Req_Valid  in  1  request present
Req_Ready  out  1  responder can accept
Req_Write  in  1  1 = store, 0 = load
Req_Funct3  in  3  RV32I funct3 of load/store
Req_Addr  in  32  byte address
Req_WData  in  32  store data, lane 0 aligned (rs2 value)
Resp_Valid  out  1  response present
Resp_Ready  in  1  requester accepts response
Resp_RData  out  32  extended load data; 0 for stores and errors
Resp_Err  out  1  access error for this response
Busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, Reset_n=0): state IDLE, wait counter 0, Resp_Valid 0, Resp_RData 0, Resp_Err 0, Busy 0, Req_Ready 1. RAM contents not cleared.
- Reset mid-transaction: abort to IDLE. An uncommitted store is discarded. No response is issued.
- FSM IDLE:
  - Req_Ready=1 (combinational from state).
  - On Req_Valid&Req_Ready: latch Write/Funct3/Addr/WData.
  - Go to WAIT with counter=WAIT_CYCLES-1, or straight to ACCESS if WAIT_CYCLES=0.
- FSM WAIT:
  - Req_Ready=0. Counter decrements each cycle.
  - Move to ACCESS on the cycle after the counter reaches 0.
- FSM ACCESS (one cycle):
  - Check errors.
  - Commit store byte-enables to RAM, or read the RAM word and extend it into the Resp_RData register.
  - Set Resp_Err. Go to RESP.
- FSM RESP:
  - Resp_Valid=1. Resp_RData/Resp_Err are held stable until Resp_Ready=1.
  - On Resp_Valid&Resp_Ready: clear Resp_Valid, go to IDLE.
  - Req_Ready is 1 again only in the following cycle; no back-to-back overlap.
- Latency: accept edge to Resp_Valid high = WAIT_CYCLES+2 rising edges.
- Store lanes:
  - SB(000): byte Addr[1:0] <= WData[7:0].
  - SH(001): half Addr[1] <= WData[15:0].
  - SW(010): full word.
- Loads:
  - LB(000) sign-extend byte; LBU(100) zero-extend byte.
  - LH(001) sign-extend half; LHU(101) zero-extend half.
  - LW(010) full word.
- Error conditions (each gives Resp_Err=1, Resp_RData=0, RAM unchanged):
  - Word index >= DEPTH_WORDS.
  - Store funct3 not in {000,001,010}.
  - Load funct3 in {011,110,111}.
- Errors still complete the full handshake with normal latency.
- Req_Valid while Req_Ready=0 is ignored; the requester must hold the request.
- Request fields are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro DATA_MEM_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are errors (Resp_Err=1, RData 0, no write):
  - halfword with Addr[0]=1;
  - word with Addr[1:0]!=0.
- Not defined: no misalignment error. Halfword uses lane Addr[1] (Addr[0] ignored). Word ignores Addr[1:0].

Test Plan:
- SW 0x12345678 @0x10, then LW @0x10 (WAIT_CYCLES=2) -> Resp_RData=0x12345678, Resp_Err=0; Resp_Valid rises exactly 4 edges after each accept.
- After the word above, SB 0xAA @0x13, then LB @0x13 -> 0xFFFFFFAA; LBU @0x13 -> 0x000000AA; LW @0x10 -> 0xAA345678.
- SH 0x8001 @0x12, then LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- LW @0x1000 with DEPTH_WORDS=1024 -> Resp_Err=1, RData=0. LH @0x11: with macro -> Err=1; without macro -> returns the half at lane 0 (0x5678 extended).
- Hold Resp_Ready=0 for 5 cycles -> Resp_Valid, Resp_RData and Resp_Err stay stable, Req_Ready=0 while Req_Valid is held high; the second request is accepted only after the response completes.
- Assert Reset_n=0 during WAIT of a SW 0xDEADBEEF @0x20 -> Resp_Valid=0 and Req_Ready=1 immediately; after release, LW @0x20 returns the prior contents, not 0xDEADBEEF.
